// File: rtl/ms_pkg.sv
// ms_pkg: definitions shared by both ends of the ms_if address/data link.
//   ms_slave_state_e : responder handshake FSM states
//   MS_AW / MS_DW    : default address and data widths used by initiator and responder
package ms_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_READY = 2'd1,
    S_WAIT  = 2'd2
  } ms_slave_state_e;

  localparam int MS_AW = 2;
  localparam int MS_DW = 8;

endpackage : ms_pkg

// File: rtl/ms_slave_regfile.sv
// ms_slave_regfile: 2**AW x DW register file with one write port and one
// registered read port (1-cycle latency, read-before-write on collision).
// Ports:
//   clk, rstn      clock, synchronous active-low reset (clears storage and read data)
//   we/waddr/wdata write port
//   raddr/rdata    read port, rdata registered
module ms_slave_regfile
  import ms_pkg::*;
#(
  parameter int AW = MS_AW,
  parameter int DW = MS_DW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] regs [DEPTH];
  logic [DW-1:0] rdata_reg;

  // Reset has priority, so a write presented while rstn is low is dropped.
  // The read samples the array before this edge's write lands, giving
  // old data when raddr == waddr.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      rdata_reg <= '0;
    end else begin
      rdata_reg <= regs[raddr];
      if (we) begin
        regs[waddr] <= wdata;
      end
    end
  end

  assign rdata = rdata_reg;

endmodule : ms_slave_regfile

// File: rtl/ms_slave.sv
// ms_slave: responder end of the ms_if link.
// Accepts addr/data at every edge where the registered sready is high,
// stores data into a register file, checks data == previous address * 4,
// and inserts wait_cfg sready-low cycles after each accepted transfer.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   addr, data           transfer from the initiator
//   sready               registered accept strobe
//   wait_cfg             wait states after each transfer (sampled live)
//   rd_addr, rd_data     register file read port, 1-cycle latency
//   xfer_cnt, err_cnt    saturating transfer / mismatch counters
//   data_err             sticky mismatch flag
module ms_slave
  import ms_pkg::*;
#(
  parameter int AW = MS_AW,
  parameter int DW = MS_DW,
  parameter int WW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          sready,
  input  logic [WW-1:0] wait_cfg,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] xfer_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          data_err
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  ms_slave_state_e state_reg, state_next;
  logic [WW-1:0]   wcnt_reg, wcnt_next;
  logic            sready_reg;
  logic [AW-1:0]   last_addr_reg;
  logic [CW-1:0]   xfer_cnt_reg;
  logic [CW-1:0]   err_cnt_reg;
  logic            data_err_reg;

  logic            accept;
  logic [DW-1:0]   exp_data;
  logic            mismatch;

  // The registered sready is the only acceptance qualifier.
  assign accept   = sready_reg;
  assign exp_data = DW'(last_addr_reg) << 2;
  assign mismatch = accept && (data != exp_data);

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    unique case (state_reg)
      S_INIT: begin
        state_next = S_READY;
      end
      S_READY: begin
        if (wait_cfg != '0) begin
          state_next = S_WAIT;
          wcnt_next  = WW'(1);
        end
      end
      S_WAIT: begin
        // >= so that lowering wait_cfg mid-wait exits on the next edge.
        if (wcnt_reg >= wait_cfg) begin
          state_next = S_READY;
        end else begin
          wcnt_next = wcnt_reg + WW'(1);
        end
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= S_INIT;
      wcnt_reg      <= '0;
      sready_reg    <= 1'b0;
      last_addr_reg <= '0;
      xfer_cnt_reg  <= '0;
      err_cnt_reg   <= '0;
      data_err_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wcnt_reg   <= wcnt_next;
      sready_reg <= (state_next == S_READY);
      if (accept) begin
        last_addr_reg <= addr;
        if (xfer_cnt_reg != CNT_MAX) begin
          xfer_cnt_reg <= xfer_cnt_reg + CW'(1);
        end
      end
      if (mismatch) begin
        data_err_reg <= 1'b1;
        if (err_cnt_reg != CNT_MAX) begin
          err_cnt_reg <= err_cnt_reg + CW'(1);
        end
      end
    end
  end

  ms_slave_regfile #(
    .AW(AW),
    .DW(DW)
  ) u_regfile (
    .clk   (clk),
    .rstn  (rstn),
    .we    (accept),
    .waddr (addr),
    .wdata (data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign sready   = sready_reg;
  assign xfer_cnt = xfer_cnt_reg;
  assign err_cnt  = err_cnt_reg;
  assign data_err = data_err_reg;

endmodule : ms_slave

// File: tb/tb_ms_slave.sv
// Self-checking bench for ms_slave: a vector table of transfers with
// hand-derived expected counters/read data, followed by hand-written
// sequences for read/write collision, reset mid-wait and counter saturation.
module tb_ms_slave;

  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int WW  = 4;
  localparam int CW  = 16;
  localparam int CWS = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [WW-1:0] wait_cfg;
  logic [AW-1:0] rd_addr;

  logic           sready;
  logic [DW-1:0]  rd_data;
  logic [CW-1:0]  xfer_cnt;
  logic [CW-1:0]  err_cnt;
  logic           data_err;

  logic           sready_s;
  logic [DW-1:0]  rd_data_s;
  logic [CWS-1:0] xfer_cnt_s;
  logic [CWS-1:0] err_cnt_s;
  logic           data_err_s;

  always #5 clk = ~clk;

  ms_slave #(.AW(AW), .DW(DW), .WW(WW), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .data(data), .sready(sready),
    .wait_cfg(wait_cfg), .rd_addr(rd_addr), .rd_data(rd_data),
    .xfer_cnt(xfer_cnt), .err_cnt(err_cnt), .data_err(data_err)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  ms_slave #(.AW(AW), .DW(DW), .WW(WW), .CW(CWS)) dut_sat (
    .clk(clk), .rstn(rstn), .addr(addr), .data(data), .sready(sready_s),
    .wait_cfg(wait_cfg), .rd_addr(rd_addr), .rd_data(rd_data_s),
    .xfer_cnt(xfer_cnt_s), .err_cnt(err_cnt_s), .data_err(data_err_s)
  );

  typedef struct {
    logic [WW-1:0] w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] ra;
    int            gap;   // expected sready-low cycles before this transfer, -1 = skip
    int            xfer;
    int            err;
    logic          derr;
    int            rd;    // expected rd_data after the accept edge, -1 = skip
  } vec_t;

  typedef struct {
    int   xfer;
    int   err;
    logic derr;
    int   rd;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[11];

  function automatic vec_t mk(input int w, input int a, input int d, input int ra,
                              input int gap, input int xfer, input int err,
                              input int derr, input int rd);
    vec_t v;
    v.w = WW'(w); v.a = AW'(a); v.d = DW'(d); v.ra = AW'(ra);
    v.gap = gap; v.xfer = xfer; v.err = err; v.derr = derr[0]; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int gap);
    gap = 0;
    while (sready !== 1'b1 && gap < 40) begin
      tick();
      gap++;
    end
    if (sready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: sready=%b after %0d cycles, expected 1", sready, gap);
    end
  endtask

  task automatic do_xfer(input vec_t v, input string tag);
    int   gap;
    exp_t e;
    wait_ready(gap);
    if (v.gap >= 0) chk({tag, " gap"}, gap, v.gap);
    wait_cfg = v.w;
    addr     = v.a;
    data     = v.d;
    rd_addr  = v.ra;
    e.xfer = v.xfer; e.err = v.err; e.derr = v.derr; e.rd = v.rd;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    $display("%s: addr=%0d data=%02h wait=%0d gap=%0d -> xfer_cnt=%0d err_cnt=%0d data_err=%0b rd[%0d]=%02h",
             tag, v.a, v.d, v.w, gap, xfer_cnt, err_cnt, data_err, v.ra, rd_data);
    chk({tag, " xfer_cnt"}, 32'(xfer_cnt), e.xfer);
    chk({tag, " err_cnt"}, 32'(err_cnt), e.err);
    chk({tag, " data_err"}, 32'(data_err), 32'(e.derr));
    if (e.rd >= 0) chk({tag, " rd_data"}, 32'(rd_data), e.rd);
  endtask

  initial begin
    int   prev_a;
    int   a;
    int   exp_s;
    vec_t v;

    //            w  a  d     ra gap xfer err derr rd
    vecs[0]  = mk(0, 0, 'h00, 0, 1,  1,   0,  0,   'h00);
    vecs[1]  = mk(0, 1, 'h00, 0, 0,  2,   0,  0,   'h00);
    vecs[2]  = mk(0, 2, 'h04, 1, 0,  3,   0,  0,   'h00);
    vecs[3]  = mk(0, 3, 'h08, 3, 0,  4,   0,  0,   'h00); // collision: old value
    vecs[4]  = mk(2, 0, 'h0C, 3, 0,  5,   0,  0,   'h08); // new value one cycle later
    vecs[5]  = mk(2, 1, 'h00, 2, 2,  6,   0,  0,   'h04);
    vecs[6]  = mk(2, 2, 'h55, 0, 2,  7,   1,  1,   'h0C); // corrupt: expected 04
    vecs[7]  = mk(2, 3, 'h08, 2, 2,  8,   1,  1,   'h55);
    vecs[8]  = mk(1, 0, 'h0C, 3, 2,  9,   1,  1,   'h08);
    vecs[9]  = mk(0, 1, 'h00, 2, 1,  10,  1,  1,   'h55);
    vecs[10] = mk(15, 2, 'h04, 2, 0, 11,  1,  1,   'h55); // collision on addr 2

    rstn = 1'b0; addr = '0; data = '0; wait_cfg = '0; rd_addr = '0;
    repeat (3) tick();
    chk("reset sready", 32'(sready), 0);
    chk("reset rd_data", 32'(rd_data), 0);
    chk("reset xfer_cnt", 32'(xfer_cnt), 0);
    chk("reset err_cnt", 32'(err_cnt), 0);
    chk("reset data_err", 32'(data_err), 0);
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_xfer(vecs[i], $sformatf("vec%0d", i));
    end

    // In the 15-cycle wait: collision result, then full register readback.
    tick();
    chk("collision new rd_data", 32'(rd_data), 'h04);
    chk("wait sready", 32'(sready), 0);
    rd_addr = 2'd0; tick(); chk("regs[0]", 32'(rd_data), 'h0C);
    rd_addr = 2'd1; tick(); chk("regs[1]", 32'(rd_data), 'h00);
    rd_addr = 2'd3; tick(); chk("regs[3]", 32'(rd_data), 'h08);

    // Reset in S_WAIT with wait_cfg=5, wcnt=3.
    do_xfer(mk(5, 3, 'h08, 2, -1, 12, 1, 1, 'h04), "pre_reset");
    tick(); chk("wait1 sready", 32'(sready), 0);
    tick(); chk("wait2 sready", 32'(sready), 0);
    rstn = 1'b0;
    tick();
    $display("reset mid-wait: sready=%0b xfer_cnt=%0d err_cnt=%0d data_err=%0b",
             sready, xfer_cnt, err_cnt, data_err);
    chk("midrst sready", 32'(sready), 0);
    chk("midrst xfer_cnt", 32'(xfer_cnt), 0);
    chk("midrst err_cnt", 32'(err_cnt), 0);
    chk("midrst data_err", 32'(data_err), 0);
    chk("midrst sat xfer_cnt", 32'(xfer_cnt_s), 0);
    rstn = 1'b1; wait_cfg = 4'd15; addr = '0; data = '0; rd_addr = 2'd2;
    tick();
    chk("post-rst S_READY sready", 32'(sready), 1);
    chk("post-rst regs[2]", 32'(rd_data), 0);
    chk("post-rst xfer_cnt", 32'(xfer_cnt), 0);
    rd_addr = 2'd3;
    tick();
    chk("post-rst accept xfer_cnt", 32'(xfer_cnt), 1);
    chk("post-rst wait sready", 32'(sready), 0);
    chk("post-rst regs[3]", 32'(rd_data), 0);
    rd_addr = 2'd0;
    tick();
    chk("post-rst regs[0]", 32'(rd_data), 0);

    // Saturation: 20 back-to-back correct transfers.
    prev_a = 0;
    for (int i = 1; i <= 20; i++) begin
      a = i % 4;
      v = mk(0, a, (prev_a * 4) & 'hFF, 0, -1, 1 + i, 0, 0, -1);
      do_xfer(v, $sformatf("sat%0d", i));
      exp_s = (1 + i > 15) ? 15 : 1 + i;
      chk($sformatf("sat%0d narrow xfer_cnt", i), 32'(xfer_cnt_s), exp_s);
      prev_a = a;
    end
    chk("sat narrow err_cnt", 32'(err_cnt_s), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ms_slave
